// File: rtl/freepdk45_sram_pkg.sv
// Shared types and helpers for the parametrised FreePDK45 1W1R SRAM model.
package freepdk45_sram_pkg;

  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    INIT  = ST_INIT,
    READY = ST_READY
  } state_e;

  // Lane geometry must tile the word exactly and fit the merge helper.
  function automatic bit lane_cfg_ok(input int unsigned data_width,
                                     input int unsigned write_size);
    return (write_size != 0) && (data_width % write_size == 0) &&
           (data_width <= MERGE_MAX_W);
  endfunction

  // Callers zero-extend into MERGE_MAX_W and truncate the result back.
  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] mask,
    input int unsigned            write_size
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
      if (mask[MERGE_IDX_W'(b / write_size)]) begin
        res[MERGE_IDX_W'(b)] = new_word[MERGE_IDX_W'(b)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/freepdk45_sram_1w1r_param_clear_seq.sv
// INIT/READY sequencer: sweeps the clear pointer over every word after reset.
module sram_clear_seq
  import freepdk45_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) state_q <= READY;
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign clr_we    = (state_q == INIT);
  assign init_busy = (state_q == INIT);
  assign clr_addr  = ptr_q;

endmodule

// File: rtl/freepdk45_sram_1w1r_param.sv
// Parametrised single-clock 1W1R SRAM with clear sequencer and collision flag.
// FREEPDK45_SRAM_BYPASS_EN: collision reads return the merged write data.
module freepdk45_sram_1w1r_param
  import freepdk45_sram_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              ADDR_WIDTH = 7,
  parameter int unsigned              WRITE_SIZE = 8,
  parameter int unsigned              OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0
) (
  input  logic                             clk0,
  input  logic                             rst_n,
  input  logic                             csb0,
  input  logic [DATA_WIDTH/WRITE_SIZE-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             dout1_valid,
  output logic                             init_busy,
  output logic                             collision
);

  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

  if (!lane_cfg_ok(DATA_WIDTH, WRITE_SIZE)) begin : g_bad_lane_cfg
    $error("DATA_WIDTH must be a non-zero multiple of WRITE_SIZE");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  wr_en;
  logic                  rd_en;
  logic                  rd_col;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_en  = !csb0 && !init_busy;
  assign rd_en  = !csb1 && !init_busy;
  assign rd_col = wr_en && rd_en && (addr0 == addr1);

  assign wr_merged = DATA_WIDTH'(lane_merge(MERGE_MAX_W'(mem[addr0]),
                                            MERGE_MAX_W'(din0),
                                            MERGE_MAX_W'(wmask0),
                                            WRITE_SIZE));

`ifdef FREEPDK45_SRAM_BYPASS_EN
  assign rd_word = rd_col ? wr_merged : mem[addr1];
`else
  assign rd_word = mem[addr1];
`endif

  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[addr0] <= wr_merged;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  rd_col_q;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_col_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_col_q   <= rd_col;
      if (rd_en) rd_data_q <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_col_q;

    always_ff @(posedge clk0) begin
      if (!rst_n) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
        out_col_q   <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        out_col_q   <= rd_col_q;
        if (rd_valid_q) out_data_q <= rd_data_q;
      end
    end

    assign dout1       = out_data_q;
    assign dout1_valid = out_valid_q;
    assign collision   = out_col_q;
  end else begin : g_no_out_reg
    assign dout1       = rd_data_q;
    assign dout1_valid = rd_valid_q;
    assign collision   = rd_col_q;
  end

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Bench for freepdk45_sram_1w1r_param: latency-1 and latency-2 instances vs. a word-array model.
module tb_freepdk45_sram_1w1r_param;

`ifdef FREEPDK45_SRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int unsigned DEPTH = 128;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        csb0, csb1;
  logic [3:0]  wmask0;
  logic [6:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] dout1_a, dout1_b;
  logic        dout1_valid_a, dout1_valid_b;
  logic        init_busy_a, init_busy_b;
  logic        collision_a, collision_b;

  always #5 clk0 = ~clk0;

  freepdk45_sram_1w1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WRITE_SIZE(8), .OUT_REG(0)) dut_a (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dout1_valid(dout1_valid_a),
    .init_busy(init_busy_a), .collision(collision_a));

  freepdk45_sram_1w1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WRITE_SIZE(8), .OUT_REG(1)) dut_b (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dout1_valid(dout1_valid_b),
    .init_busy(init_busy_b), .collision(collision_b));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: word array, busy countdown, and the result seen one and two edges after a read.
  logic [31:0] mem_m [DEPTH];
  int          busy_left = DEPTH;
  logic [31:0] e1_d = '0, e2_d = '0;
  logic        e1_v = 1'b0, e2_v = 1'b0, e1_c = 1'b0, e2_c = 1'b0;

  function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    bit          busy_now, rd, wr, col;
    logic [31:0] stored, merged;
    if (!rst_n) begin
      busy_left = DEPTH;
      e1_d = '0; e1_v = 1'b0; e1_c = 1'b0;
      e2_d = '0; e2_v = 1'b0; e2_c = 1'b0;
      return;
    end
    busy_now = (busy_left > 0);
    rd       = !csb1 && !busy_now;
    wr       = !csb0 && !busy_now;
    col      = rd && wr && (addr0 == addr1);
    stored   = mem_m[addr1];
    merged   = merge_m(stored, din0, wmask0);
    e2_d = e1_d; e2_v = e1_v; e2_c = e1_c;
    e1_v = rd;
    e1_c = col;
    if (rd) e1_d = (col && BYPASS) ? merged : stored;
    if (wr) mem_m[addr0] = merge_m(mem_m[addr0], din0, wmask0);
    if (busy_now) begin
      mem_m[DEPTH - busy_left] = '0;
      busy_left--;
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    model_edge();
    #1;
    check("busy_a",  init_busy_a,   busy_left > 0);
    check("busy_b",  init_busy_b,   busy_left > 0);
    check("valid_a", dout1_valid_a, e1_v);
    check("col_a",   collision_a,   e1_c);
    check("dout_a",  dout1_a,       e1_d);
    check("valid_b", dout1_valid_b, e2_v);
    check("col_b",   collision_b,   e2_c);
    check("dout_b",  dout1_b,       e2_d);
  endtask

  task automatic idle();
    csb0 = 1'b1; csb1 = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
    tick();
    csb0 = 1'b1;
  endtask

  task automatic rd(input logic [6:0] a);
    csb1 = 1'b0; addr1 = a; csb0 = 1'b1;
    tick();
    csb1 = 1'b1;
  endtask

  task automatic rand_ports();
    csb0   = 1'($urandom_range(0, 1));
    csb1   = 1'($urandom_range(0, 1));
    addr0  = 7'($urandom_range(0, 127));
    addr1  = 7'($urandom_range(0, 127));
    din0   = $urandom;
    wmask0 = 4'($urandom_range(0, 15));
  endtask

  // Counts cycles with init_busy high until it drops; bounded.
  task automatic count_busy(output int n, input bit poke_100);
    n = 0;
    while (init_busy_a && n < 300) begin
      if (poke_100) begin
        csb0 = 1'b0; addr0 = 7'd100; din0 = 32'hFFFF_FFFF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 7'd100;
      end else begin
        rand_ports();
      end
      tick();
      n++;
    end
    csb0 = 1'b1; csb1 = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [4:0]  va, vb;
    logic [31:0] col_exp;

    rst_n = 1'b0; csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;

    // Reset with junk on the ports.
    repeat (3) begin
      rand_ports();
      tick();
    end
    check("rst_dout",  dout1_a, 32'h0);
    check("rst_valid", dout1_valid_a, 1'b0);
    check("rst_col",   collision_a, 1'b0);
    check("rst_busy",  init_busy_a, 1'b1);

    // First clear with random traffic that must be ignored.
    rst_n = 1'b1;
    count_busy(n, 1'b0);
    check("init_len", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      rd(7'(a));
      check("init_clear", dout1_a, 32'h0);
      check("init_rd_valid", dout1_valid_a, 1'b1);
    end
    idle();

    // Masked read-modify-write.
    wr(7'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(7'd5, 32'h1122_3344, 4'b0101);
    rd(7'd5);
    check("rmw_a", dout1_a, 32'hDE22_BE44);
    idle();
    check("rmw_b", dout1_b, 32'hDE22_BE44);

    // Back-to-back reads.
    for (int a = 1; a <= 3; a++) wr(7'(a), 32'h100 + 32'(a), 4'hF);
    idle(); idle();
    va = '0; vb = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        csb1 = 1'b0; addr1 = 7'(i + 1);
      end else begin
        csb1 = 1'b1;
      end
      tick();
      va[i] = dout1_valid_a;
      vb[i] = dout1_valid_b;
      if (i == 2) check("b2b_a_last", dout1_a, 32'h103);
      if (i == 3) check("b2b_b_last", dout1_b, 32'h103);
    end
    check("b2b_va", 32'(va), 32'b00111);
    check("b2b_vb", 32'(vb), 32'b01110);

    // Same-address collision.
    col_exp = BYPASS ? 32'hAAAA_5555 : 32'hAAAA_AAAA;
    wr(7'd9, 32'hAAAA_AAAA, 4'hF);
    csb0 = 1'b0; addr0 = 7'd9; din0 = 32'h5555_5555; wmask0 = 4'b0011;
    csb1 = 1'b0; addr1 = 7'd9;
    tick();
    check("col_flag_a", collision_a, 1'b1);
    check("col_data_a", dout1_a, col_exp);
    idle();
    check("col_flag_b", collision_b, 1'b1);
    check("col_data_b", dout1_b, col_exp);
    rd(7'd9);
    check("col_after", dout1_a, 32'hAAAA_5555);
    idle();

    // Reset at clear pointer 40, then restart.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (40) idle();
    check("mid_busy", init_busy_a, 1'b1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    count_busy(n, 1'b1);
    check("reinit_len", n, DEPTH);
    rd(7'd100);
    check("a100_before", dout1_a, 32'h0);
    wr(7'd100, 32'h1, 4'hF);
    rd(7'd100);
    check("a100_after", dout1_a, 32'h1);
    idle();

    // Random traffic, mostly on a small address window, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      rand_ports();
      if ($urandom_range(0, 3) != 0) begin
        addr0 = 7'($urandom_range(0, 15));
        addr1 = 7'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 799) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
